// File: rtl/packet_tx_if.sv
//------------------------------------------------------------------------------
// packet_tx_if
// Memory-mapped CPU bus plus TX FIFO push port for the packet transmitter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface packet_tx_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        out_push;
  logic        out_nfull;
  logic [63:0] out_data;
  logic        out_end;
  logic [7:0]  out_phase_shift;

  // Environment view: drives the bus request and the FIFO ready
  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, out_nfull,
    input  mem_ready, mem_rdata, out_push, out_data, out_end, out_phase_shift
  );

  // Device view
  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, out_nfull,
    output mem_ready, mem_rdata, out_push, out_data, out_end, out_phase_shift
  );
endinterface

`default_nettype wire

// File: rtl/packet_tx_device.sv
//------------------------------------------------------------------------------
// packet_tx_device
// Memory-mapped packet transmitter: CPU-staged 64-bit words drain through a
// one-entry holding register into the TX FIFO. Optional macro
// PACKET_TX_COUNT_EN adds word/packet push counters at 0x20/0x24.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module packet_tx_device #(
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  packet_tx_if.slave   bus
);

  localparam logic [31:0] c_OFF_DATA_LO = 32'h04;
  localparam logic [31:0] c_OFF_DATA_HI = 32'h08;
  localparam logic [31:0] c_OFF_END     = 32'h0C;
  localparam logic [31:0] c_OFF_STATUS  = 32'h10;
  localparam logic [31:0] c_OFF_COMMIT  = 32'h14;
  localparam logic [31:0] c_OFF_PHASE   = 32'h18;
  localparam logic [31:0] c_OFF_OVF_CLR = 32'h1C;
`ifdef PACKET_TX_COUNT_EN
  localparam logic [31:0] c_OFF_WORDS   = 32'h20;
  localparam logic [31:0] c_OFF_PKTS    = 32'h24;
`endif

  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic [31:0] r_data_lo;
  logic [31:0] r_data_hi;
  logic        r_end;
  logic [63:0] r_hold_data;
  logic        r_hold_end;
  logic        r_pending;
  logic        r_ovf;
  logic [7:0]  r_phase;

  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_off;
  logic        w_push;
  logic        w_commit;
  logic        w_overflow;
  logic        w_ovf_clr;
  logic [31:0] w_rdata;

  // A request is taken only while no response is outstanding, so a master
  // that keeps mem_valid high until it sees mem_ready is served exactly once.
  assign w_accept   = bus.mem_valid & ~r_mem_ready;
  assign w_wr       = w_accept & (|bus.mem_wstrb);
  assign w_rd       = w_accept & ~(|bus.mem_wstrb);
  assign w_off      = bus.mem_addr - ADDR_BASE;

  assign w_push     = r_pending & bus.out_nfull;
  assign w_commit   = w_wr & (w_off == c_OFF_COMMIT);
  assign w_overflow = w_commit & r_pending & ~bus.out_nfull;
  assign w_ovf_clr  = w_wr & (w_off == c_OFF_OVF_CLR) & bus.mem_wdata[0];

`ifdef PACKET_TX_COUNT_EN
  logic [31:0] r_word_cnt;
  logic [31:0] r_pkt_cnt;
  logic        w_cnt_clr;

  assign w_cnt_clr = w_wr & (w_off == c_OFF_WORDS);

  // Clear wins over a coincident push so software sees a clean zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= 32'd0;
      r_pkt_cnt  <= 32'd0;
    end else if (w_cnt_clr) begin
      r_word_cnt <= 32'd0;
      r_pkt_cnt  <= 32'd0;
    end else if (w_push) begin
      r_word_cnt <= r_word_cnt + 32'd1;
      if (r_hold_end) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  end
`endif

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      c_OFF_STATUS: w_rdata = {29'd0, r_ovf, r_pending, bus.out_nfull};
`ifdef PACKET_TX_COUNT_EN
      c_OFF_WORDS:  w_rdata = r_word_cnt;
      c_OFF_PKTS:   w_rdata = r_pkt_cnt;
`endif
      default:      w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_mem_ready <= w_accept;
      r_mem_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_lo <= 32'd0;
      r_data_hi <= 32'd0;
      r_end     <= 1'b0;
      r_phase   <= 8'd0;
    end else if (w_wr) begin
      case (w_off)
        c_OFF_DATA_LO: r_data_lo <= bus.mem_wdata;
        c_OFF_DATA_HI: r_data_hi <= bus.mem_wdata;
        c_OFF_END:     r_end     <= bus.mem_wdata[0];
        c_OFF_PHASE:   r_phase   <= bus.mem_wdata[7:0];
        default:       ;
      endcase
    end
  end

  // A commit that coincides with a push reloads the now-free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= 64'd0;
      r_hold_end  <= 1'b0;
      r_pending   <= 1'b0;
    end else if (w_commit && !w_overflow) begin
      r_hold_data <= {r_data_hi, r_data_lo};
      r_hold_end  <= r_end;
      r_pending   <= 1'b1;
    end else if (w_push) begin
      r_pending   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_overflow) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.mem_ready       = r_mem_ready;
  assign bus.mem_rdata       = r_mem_rdata;
  assign bus.out_push        = w_push;
  assign bus.out_data        = r_hold_data;
  assign bus.out_end         = r_hold_end;
  assign bus.out_phase_shift = r_phase;

endmodule

`default_nettype wire
